// File: rtl/bfsk_modulator.sv
// rtl/bfsk_modulator.sv - binary FSK I/Q transmitter: DC sync preamble then one tone burst per bit
//
// Ports:
//   clk         sample clock, one I/Q sample per cycle
//   reset_n     asynchronous active-low reset
//   start       1-cycle pulse that begins a frame (ignored while busy)
//   bit_in      next data bit (0 -> FREQ0 tone, 1 -> FREQ1 tone)
//   bit_valid   bit_in is valid; taken only when bit_ready is high
//   bit_ready   high in the last sample cycle of the preamble or of each symbol
//   i_out       signed 18-bit I sample, registered
//   q_out       signed 18-bit Q sample, registered
//   out_valid   i_out/q_out carry a frame sample
//   busy        frame in progress
//   frame_done  1-cycle pulse after the last symbol sample when no further bit was taken
//
// Optional build macro: FSK_TX_CONT_PHASE_EN selects continuous-phase FSK
// (phase carried across symbol boundaries instead of cleared to 0).

`timescale 1ns/1ps

module bfsk_modulator #(
    parameter int                 SYNC_LEN   = 9,
    parameter logic signed [17:0] SYNC_LEVEL = 18'sd4096,
    parameter int                 SYMBOL_LEN = 100,
    parameter logic [31:0]        FREQ0_INC  = 32'd47721859,
    parameter logic [31:0]        FREQ1_INC  = 32'd95443718,
    parameter int                 AMPLITUDE  = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic signed [17:0] i_out,
    output logic signed [17:0] q_out,
    output logic               out_valid,
    output logic               busy,
    output logic               frame_done
);

    localparam int CW = $clog2(SYMBOL_LEN > SYNC_LEN ? SYMBOL_LEN : SYNC_LEN);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL_LEN - 1);

    // Quarter-wave folded cosine, evaluated at elaboration with a fixed-point
    // Taylor series (2^30 scale) so the table becomes a constant ROM.
    function automatic logic signed [17:0] cos_entry(input int idx);
        longint one;
        longint x;
        longint term;
        longint sum;
        longint val;
        int     j;
        logic   neg;
        one = 64'sd1073741824;
        if (idx <= 256) begin
            j = idx;        neg = 1'b0;
        end else if (idx <= 512) begin
            j = 512 - idx;  neg = 1'b1;
        end else if (idx <= 768) begin
            j = idx - 512;  neg = 1'b1;
        end else begin
            j = 1024 - idx; neg = 1'b0;
        end
        // x = 2*pi*j/1024 in 2^30 fixed point (pi * 2^30 = 3373259426)
        x    = (64'sd3373259426 * longint'(j)) / 64'sd512;
        term = one;
        sum  = one;
        for (int n = 1; n <= 12; n++) begin
            term = -((((term * x) / one) * x) / one) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        if (sum < 0) begin
            sum = 0;
        end
        val = (longint'(AMPLITUDE) * sum + one / 2) / one;
        return neg ? 18'(-val) : 18'(val);
    endfunction

    logic signed [17:0] cos_lut [1024];

    for (genvar g = 0; g < 1024; g++) begin : g_lut
        localparam logic signed [17:0] LUT_VAL = cos_entry(g);
        assign cos_lut[g] = LUT_VAL;
    end

    typedef enum logic [1:0] {IDLE, SYNC, SYMBOL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [31:0]   phase, phase_n;
    logic [31:0]   inc, inc_n;
    logic          frame_done_n;
    logic          accept;
    logic [31:0]   bit_inc;
    logic [9:0]    i_idx;
    logic [9:0]    q_idx;

    assign bit_ready = ((state == SYNC)   && (count == SYNC_LAST)) ||
                       ((state == SYMBOL) && (count == SYM_LAST));
    assign accept    = bit_valid & bit_ready;
    assign busy      = (state != IDLE);
    assign bit_inc   = bit_in ? FREQ1_INC : FREQ0_INC;

    // Outputs are registered from the next-state values so the sample for
    // count k is on the pins in the same cycle that count == k.
    assign i_idx = phase_n[31:22];
    assign q_idx = phase_n[31:22] + 10'd768;   // cos(theta + 3pi/2) = sin(theta)

    always_comb begin
        state_n      = state;
        count_n      = count;
        phase_n      = phase;
        inc_n        = inc;
        frame_done_n = 1'b0;
        case (state)
            IDLE: begin
                phase_n = '0;
                count_n = '0;
                if (start) begin
                    state_n = SYNC;
                end
            end
            SYNC: begin
                phase_n = '0;
                if (count == SYNC_LAST) begin
                    count_n = '0;
                    if (accept) begin
                        state_n = SYMBOL;
                        inc_n   = bit_inc;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    count_n = count + CW'(1);
                end
            end
            SYMBOL: begin
                if (count == SYM_LAST) begin
                    count_n = '0;
                    if (accept) begin
                        inc_n = bit_inc;
`ifdef FSK_TX_CONT_PHASE_EN
                        phase_n = phase + inc;
`else
                        phase_n = '0;
`endif
                    end else begin
                        state_n      = IDLE;
                        phase_n      = '0;
                        frame_done_n = 1'b1;
                    end
                end else begin
                    count_n = count + CW'(1);
                    phase_n = phase + inc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            phase      <= '0;
            inc        <= '0;
            i_out      <= '0;
            q_out      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            phase      <= phase_n;
            inc        <= inc_n;
            out_valid  <= (state_n != IDLE);
            frame_done <= frame_done_n;
            case (state_n)
                SYNC: begin
                    i_out <= SYNC_LEVEL;
                    q_out <= '0;
                end
                SYMBOL: begin
                    i_out <= cos_lut[i_idx];
                    q_out <= -cos_lut[q_idx];
                end
                default: begin
                    i_out <= '0;
                    q_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfsk_modulator.sv
// tb/tb_bfsk_modulator.sv - self-checking bench for bfsk_modulator

`timescale 1ns/1ps

module tb_bfsk_modulator;

    localparam bit [31:0] F0     = 32'd47721859;
    localparam bit [31:0] F1     = 32'd95443718;
    localparam real       AMP    = 100000.0;
    localparam real       TWO_PI = 6.283185307179586;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               bit_in = 1'b0;
    logic               bit_valid = 1'b0;
    logic               bit_ready;
    logic signed [17:0] i_out;
    logic signed [17:0] q_out;
    logic               out_valid;
    logic               busy;
    logic               frame_done;

    always #5 clk = ~clk;

    bfsk_modulator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .i_out      (i_out),
        .q_out      (q_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        int i;
        int q;
        bit v;
        bit b;
        bit r;
        bit d;
    } exp_t;

    exp_t exp_q[$];
    bit   tx_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   printed  = 0;
    int   cyc      = 0;
    bit   model_on = 1'b0;

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int tone_i(input bit [31:0] p);
        real a;
        a = TWO_PI * real'(p[31:22]) / 1024.0;
        return rnd(AMP * $cos(a));
    endfunction

    function automatic int tone_q(input bit [31:0] p);
        real a;
        a = TWO_PI * real'(p[31:22]) / 1024.0;
        return -rnd(AMP * $sin(a));
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic check(input string name, input int act, input int req, input int tol);
        checks++;
        if (absdiff(act, req) > tol) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int i, input int q, input bit v, input bit b, input bit r, input bit d);
        exp_t e;
        e.i = i; e.q = q; e.v = v; e.b = b; e.r = r; e.d = d;
        exp_q.push_back(e);
    endtask

    // Expected per-cycle samples of one frame, from the frame definition:
    // preamble, then SYMBOL_LEN samples per bit at phase p0 + k*INC, then done.
    task automatic push_frame(input int n, input logic [63:0] bits);
        bit [31:0] p;
        bit [31:0] inc;
        for (int c = 0; c < 9; c++) begin
            push_exp(4096, 0, 1'b1, 1'b1, c == 8, 1'b0);
        end
        p = '0;
        for (int s = 0; s < n; s++) begin
            inc = bits[s] ? F1 : F0;
`ifndef FSK_TX_CONT_PHASE_EN
            p = '0;
`endif
            for (int k = 0; k < 100; k++) begin
                push_exp(tone_i(p), tone_q(p), 1'b1, 1'b1, k == 99, 1'b0);
                p = p + inc;
            end
        end
        if (n > 0) begin
            push_exp(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Per-cycle comparison against the model; an empty queue means idle.
    always @(negedge clk) begin
        exp_t e;
        if (model_on) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.i = 0; e.q = 0; e.v = 1'b0; e.b = 1'b0; e.r = 1'b0; e.d = 1'b0;
            end
            checks++;
            if (absdiff(int'(i_out), e.i) > 1 || absdiff(int'(q_out), e.q) > 1 ||
                out_valid !== e.v || busy !== e.b || bit_ready !== e.r || frame_done !== e.d) begin
                failures++;
                if (printed < 40) begin
                    printed++;
                    $display("FAIL model cyc=%0d actual i=%0d q=%0d v=%b busy=%b rdy=%b done=%b required i=%0d q=%0d v=%b busy=%b rdy=%b done=%b",
                             cyc, i_out, q_out, out_valid, busy, bit_ready, frame_done,
                             e.i, e.q, e.v, e.b, e.r, e.d);
                end
            end
        end
        cyc++;
    end

    // Bit source: offers the queue head, pops it on a ready&valid handshake.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = bit_valid && bit_ready;
            @(posedge clk);
            #1;
            if (acc && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
            end
            bit_valid = (tx_q.size() > 0);
            bit_in    = (tx_q.size() > 0) ? tx_q[0] : 1'b0;
        end
    end

    // Hand-computed literals for frame 1,0,1 (c = output cycle after start).
    task automatic pin_a(input int c);
        case (c)
            0: begin
                check("sync_i", int'(i_out), 4096, 0);
                check("sync_q", int'(q_out), 0, 0);
            end
            8:   check("sync_ready", int'(bit_ready), 1, 0);
            9: begin
                check("s0k0_i", int'(i_out), 100000, 1);
                check("s0k0_q", int'(q_out), 0, 1);
            end
            10: begin
                check("s0k1_i", int'(i_out), 99090, 1);
                check("s0k1_q", int'(q_out), -13458, 1);
            end
            54:  check("s0k45_i", int'(i_out), 100000, 1);
`ifndef FSK_TX_CONT_PHASE_EN
            109: begin
                check("s1k0_i", int'(i_out), 100000, 1);
                check("s1k0_q", int'(q_out), 0, 1);
            end
            110: begin
                check("s1k1_i", int'(i_out), 99772, 1);
                check("s1k1_q", int'(q_out), -6744, 1);
            end
            199: begin
                check("s1k90_i", int'(i_out), 100000, 1);
                check("s1k90_q", int'(q_out), 0, 1);
            end
            209: check("s2k0_i", int'(i_out), 100000, 1);
`endif
            309: begin
                check("done_pulse", int'(frame_done), 1, 0);
                check("done_valid", int'(out_valid), 0, 0);
            end
            default: ;
        endcase
    endtask

    // Called at negedge+1; returns at negedge+1 of the done (or underrun idle) cycle.
    task automatic run_frame(input int n, input logic [63:0] bits, input bit give_bits,
                             input bit poke, input bit pin);
        int total;
        push_frame(give_bits ? n : 0, bits);
        if (give_bits) begin
            for (int k = 0; k < n; k++) begin
                tx_q.push_back(bits[k]);
            end
        end
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        total = give_bits ? 9 + 100 * n : 9;
        for (int c = 0; c < total; c++) begin
            if (pin) begin
                pin_a(c);
            end
            start = poke && (c == 50);
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        if (pin) begin
            pin_a(total);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_i"},     int'(i_out), 0, 0);
        check({tag, "_q"},     int'(q_out), 0, 0);
        check({tag, "_valid"}, int'(out_valid), 0, 0);
        check({tag, "_busy"},  int'(busy), 0, 0);
        check({tag, "_ready"}, int'(bit_ready), 0, 0);
        check({tag, "_done"},  int'(frame_done), 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_cleared("reset");
        reset_n  = 1'b1;
        model_on = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        run_frame(3, 64'b101, 1'b1, 1'b1, 1'b1);
        run_frame(4, 64'b0110, 1'b1, 1'b0, 1'b0);
        run_frame(2, 64'b01, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;

        run_frame(0, 64'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("underrun_busy", int'(busy), 0, 0);

        run_frame(8, 64'hA5, 1'b1, 1'b0, 1'b0);
        run_frame(2, 64'b10, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;

        model_on = 1'b0;
        tx_q.push_back(1'b1);
        tx_q.push_back(1'b1);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        check("midframe_busy_before", int'(busy), 1, 0);
        reset_n = 1'b0;
        #1;
        check_cleared("async_reset");
        tx_q.delete();
        exp_q.delete();
        @(negedge clk);
        #1;
        reset_n  = 1'b1;
        model_on = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        run_frame(1, 64'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
